// File: rtl/quick_spi_cmd_sequencer.sv
// Command sequencer in front of the quick_spi master: buffers register read/write
// commands, runs them one at a time and returns read data with a watchdog on each transfer.
module quick_spi_cmd_sequencer #(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [1:0]  cmd_slave,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_error,
  output logic        busy,
  output logic        timeout,
  output logic        spi_enable,
  output logic        spi_start_transaction,
  output logic        spi_operation,
  output logic [1:0]  spi_slave,
  output logic [15:0] spi_outgoing_data,
  input  logic        spi_end_of_transaction,
  input  logic [7:0]  spi_incoming_data
);

  localparam int unsigned AW   = $clog2(CMD_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0]   CountFull = CW'(CMD_DEPTH);
  localparam logic [WdW-1:0]  WdLast    = (TIMEOUT_CYCLES > 0) ? WdW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [GapW-1:0] GapLast   = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StGap} state_e;

  typedef struct packed {
    logic       op;
    logic [1:0] slave;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t          fifo_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  cmd_t          head;

  assign fifo_full  = (count_q == CountFull);
  assign fifo_empty = (count_q == '0);
  // Decoded from the registered count only; a same-cycle pop never frees a slot.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {cmd_op, cmd_slave, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            start_q, start_d;
  logic            op_q, op_d;
  logic [1:0]      slave_q, slave_d;
  logic [15:0]     out_q, out_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_error_q, rsp_error_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;
  logic            spi_enable_q;
  logic            wd_fire;

  assign wd_fire = (TIMEOUT_CYCLES != 0) && (wd_q == WdLast);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    wd_d        = wd_q;
    gap_d       = '0;
    start_d     = start_q;
    op_d        = op_q;
    slave_d     = slave_q;
    out_d       = out_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && !fifo_empty) begin
          pop     = 1'b1;
          op_d    = head.op;
          slave_d = head.slave;
          out_d   = {head.addr, head.op ? 8'h00 : head.wdata};
          start_d = 1'b1;
          wd_d    = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        wd_d = wd_q + WdW'(1);
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (spi_end_of_transaction) begin
          start_d = 1'b0;
          if (op_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = spi_incoming_data;
            rsp_error_d = 1'b0;
            state_d     = StResp;
          end else begin
            state_d = StGap;
          end
        end else if (wd_fire) begin
          start_d   = 1'b0;
          timeout_d = 1'b1;
          if (op_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_error_d = 1'b1;
            state_d     = StResp;
          end else begin
            state_d = StGap;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q;
        if (gap_q != GapLast) begin
          gap_d = gap_q + GapW'(1);
        end else if (!spi_end_of_transaction) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wd_q         <= '0;
      gap_q        <= '0;
      start_q      <= 1'b0;
      op_q         <= 1'b0;
      slave_q      <= 2'd0;
      out_q        <= 16'h0000;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_error_q  <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      spi_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
      start_q      <= start_d;
      op_q         <= op_d;
      slave_q      <= slave_d;
      out_q        <= out_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      spi_enable_q <= enable;
    end
  end

  assign rsp_valid             = rsp_valid_q;
  assign rsp_data              = rsp_data_q;
  assign rsp_error             = rsp_error_q;
  assign busy                  = busy_q;
  assign timeout               = timeout_q;
  assign spi_enable            = spi_enable_q;
  assign spi_start_transaction = start_q;
  assign spi_operation         = op_q;
  assign spi_slave             = slave_q;
  assign spi_outgoing_data     = out_q;

endmodule

// File: tb/tb_quick_spi_cmd_sequencer.sv
// Bench for quick_spi_cmd_sequencer: quick_spi responder model plus transaction and
// response scoreboards, a command vector table and hand-written corner-case sequences.
module tb_quick_spi_cmd_sequencer;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 16;
  localparam int unsigned Gap     = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [1:0]  cmd_slave;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        busy;
  logic        timeout;
  logic        spi_enable;
  logic        spi_start_transaction;
  logic        spi_operation;
  logic [1:0]  spi_slave;
  logic [15:0] spi_outgoing_data;
  logic        spi_end_of_transaction = 1'b0;
  logic [7:0]  spi_incoming_data = 8'h00;

  quick_spi_cmd_sequencer #(
    .CMD_DEPTH      (Depth),
    .TIMEOUT_CYCLES (Timeout),
    .GAP_CYCLES     (Gap)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_op                 (cmd_op),
    .cmd_slave              (cmd_slave),
    .cmd_addr               (cmd_addr),
    .cmd_wdata              (cmd_wdata),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_data               (rsp_data),
    .rsp_error              (rsp_error),
    .busy                   (busy),
    .timeout                (timeout),
    .spi_enable             (spi_enable),
    .spi_start_transaction  (spi_start_transaction),
    .spi_operation          (spi_operation),
    .spi_slave              (spi_slave),
    .spi_outgoing_data      (spi_outgoing_data),
    .spi_end_of_transaction (spi_end_of_transaction),
    .spi_incoming_data      (spi_incoming_data)
  );

  typedef struct {
    logic        op;
    logic [1:0]  slave;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] exp_out;
    logic [7:0]  exp_rdata;
  } vec_t;

  typedef struct {
    logic        op;
    logic [1:0]  slave;
    logic [15:0] out;
  } txn_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  vec_t vecs [8];
  txn_t exp_txn [$];
  rsp_t exp_rsp [$];

  int errors      = 0;
  int checks      = 0;
  int to_seen     = 0;
  int to_exp      = 0;
  int start_count = 0;

  // quick_spi responder model: reads return addr ^ 8'hD8
  bit m_mute = 1'b0;
  int m_lat  = 3;
  int m_cnt  = 0;
  bit m_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    spi_end_of_transaction = 1'b0;
    if (reset || !spi_start_transaction) begin
      m_cnt  = 0;
      m_done = 1'b0;
    end else if (!m_done) begin
      if (!m_mute && m_cnt == m_lat) begin
        spi_end_of_transaction = 1'b1;
        spi_incoming_data      = spi_outgoing_data[15:8] ^ 8'hD8;
        m_done                 = 1'b1;
      end
      m_cnt++;
    end
  end

  // Transaction monitor: ordering, fields and inter-transaction gap
  bit   prev_start = 1'b0;
  bit   have_fall  = 1'b0;
  int   low_cnt    = 0;
  txn_t mon_t;

  always @(negedge clk) begin
    if (reset) begin
      prev_start = 1'b0;
      have_fall  = 1'b0;
      low_cnt    = 0;
    end else begin
      if (spi_start_transaction && !prev_start) begin
        start_count++;
        if (have_fall) begin
          checks++;
          if (low_cnt < Gap + 1) begin
            errors++;
            $display("FAIL gap_cycles: got %0d low cycles, required >= %0d", low_cnt, Gap + 1);
          end
        end
        if (exp_txn.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got start with out=%h, required no transaction",
                   spi_outgoing_data);
        end else begin
          mon_t = exp_txn.pop_front();
          chk("txn_op", spi_operation, mon_t.op);
          chk("txn_slave", spi_slave, mon_t.slave);
          chk("txn_out", spi_outgoing_data, mon_t.out);
        end
      end
      if (!spi_start_transaction && prev_start) begin
        have_fall = 1'b1;
        low_cnt   = 0;
      end
      if (!spi_start_transaction) low_cnt++;
      prev_start = spi_start_transaction;
    end
  end

  // Response monitor: every valid cycle is held against the queue head
  rsp_t mon_r;

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data=%h err=%0d, required no response",
                 rsp_data, rsp_error);
      end else begin
        mon_r = exp_rsp[0];
        chk("rsp_data", rsp_data, mon_r.data);
        chk("rsp_error", rsp_error, mon_r.err);
        if (rsp_ready) void'(exp_rsp.pop_front());
      end
    end
    if (!reset && timeout) to_seen++;
  end

  task automatic push_cmd(input logic op, input logic [1:0] slave, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [15:0] exp_out,
                          input logic [7:0] exp_rdata, input logic exp_err);
    int   n = 0;
    txn_t t;
    rsp_t r;
    while (!cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("push_ready_wait", cmd_ready, 1);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_slave = slave;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      t.op      = op;
      t.slave   = slave;
      t.out     = exp_out;
      exp_txn.push_back(t);
      if (op) begin
        r.data = exp_rdata;
        r.err  = exp_err;
        exp_rsp.push_back(r);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic push_vec(input int i);
    push_cmd(vecs[i].op, vecs[i].slave, vecs[i].addr, vecs[i].wdata, vecs[i].exp_out,
             vecs[i].exp_rdata, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_txn.size() != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_reached", busy || exp_txn.size() != 0, 0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_slave = 2'd0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b1;

    vecs[0] = '{1'b0, 2'd1, 8'h5A, 8'h5A, 16'h5A5A, 8'h00};
    vecs[1] = '{1'b1, 2'd0, 8'h12, 8'hFF, 16'h1200, 8'hCA};
    vecs[2] = '{1'b0, 2'd2, 8'h01, 8'h80, 16'h0180, 8'h00};
    vecs[3] = '{1'b1, 2'd3, 8'hFF, 8'h12, 16'hFF00, 8'h27};
    vecs[4] = '{1'b0, 2'd3, 8'h00, 8'h00, 16'h0000, 8'h00};
    vecs[5] = '{1'b1, 2'd1, 8'h80, 8'hA5, 16'h8000, 8'h58};
    vecs[6] = '{1'b0, 2'd0, 8'hC3, 8'h3C, 16'hC33C, 8'h00};
    vecs[7] = '{1'b1, 2'd2, 8'h5A, 8'h00, 16'h5A00, 8'h82};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_spi_enable", spi_enable, 0);
    chk("rst_start", spi_start_transaction, 0);
    chk("rst_op", spi_operation, 0);
    chk("rst_slave", spi_slave, 0);
    chk("rst_out", spi_outgoing_data, 0);
    reset  = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("spi_enable_on", spi_enable, 1);

    // Single write: start one cycle after acceptance
    push_vec(0);
    chk("start_before_pop", spi_start_transaction, 0);
    @(posedge clk);
    #1;
    chk("start_after_pop", spi_start_transaction, 1);
    chk("busy_after_pop", busy, 1);
    wait_idle();

    // Read with response back-pressure and a write queued behind it
    rsp_ready = 1'b0;
    push_vec(1);
    push_vec(2);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!spi_end_of_transaction && n < 100);
    #1;
    chk("eot_start_low", spi_start_transaction, 0);
    chk("eot_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, vecs[1].exp_rdata);
      chk("stall_no_start", spi_start_transaction, 0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Fill FIFO while disabled, then release
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("spi_enable_off", spi_enable, 0);
    for (int i = 3; i < 7; i++) begin
      push_vec(i);
      chk("ready_fill", cmd_ready, (i < 6) ? 1 : 0);
    end
    chk("disabled_idle", busy, 0);
    fork
      push_vec(7);
      begin
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
      end
    join
    wait_idle();

    // Read timeout: error response
    m_mute = 1'b1;
    push_cmd(1'b1, 2'd2, 8'h33, 8'h77, 16'h3300, 8'h00, 1'b1);
    to_exp++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spi_start_transaction && n < 20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout && n < 40);
    chk("rd_timeout_cycles", n, Timeout);
    chk("rd_timeout_rsp_valid", rsp_valid, 1);
    chk("rd_timeout_start", spi_start_transaction, 0);
    @(negedge clk);
    chk("timeout_pulse_width", timeout, 0);
    @(posedge clk);
    #1;
    wait_idle();

    // Write timeout: pulse only
    push_cmd(1'b0, 2'd3, 8'hA5, 8'h3C, 16'hA53C, 8'h00, 1'b0);
    to_exp++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spi_start_transaction && n < 20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout && n < 40);
    chk("wr_timeout_cycles", n, Timeout);
    chk("wr_timeout_no_rsp", rsp_valid, 0);
    @(posedge clk);
    #1;
    wait_idle();
    m_mute = 1'b0;

    // end_of_transaction on the watchdog's last cycle wins
    m_lat = Timeout - 1;
    push_cmd(1'b1, 2'd0, 8'h44, 8'hEE, 16'h4400, 8'h9C, 1'b0);
    wait_idle();
    chk("eot_at_limit_timeouts", to_seen, to_exp);
    m_lat = 3;

    // Reset while busy with two commands queued
    m_mute = 1'b1;
    push_vec(0);
    push_vec(2);
    push_vec(6);
    @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_start", spi_start_transaction, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_busy", busy, 0);
    exp_txn.delete();
    exp_rsp.delete();
    m_mute = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = start_count;
    repeat (30) @(posedge clk);
    #1;
    chk("no_stale_txn", start_count, n);
    push_vec(1);
    wait_idle();

    chk("txn_queue_empty", exp_txn.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    chk("timeout_count", to_seen, to_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
